i2c_reg_sequencer: RTL and testbench

Command sequencer in front of `i2c_master` that turns single register-access requests into complete I2C transactions. A write becomes START, device address plus W, register byte, data byte, STOP. A read becomes START, device address plus W, register byte, repeated START, device address plus R, one data byte, STOP. The block drives the master's `enable`/`slv_addr`/`RnW`/`data_wr` command inputs by counting `busy` rising edges. It reports completion, read data, NACK and timeout on a valid/ready request port and a one-cycle response strobe.

---
 rtl/i2c_reg_sequencer.sv | 196 +++++++++++++++++++
 tb/tb_i2c_reg_sequencer.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_reg_sequencer.sv
// Register-access sequencer in front of an i2c_master: expands one read or write
// request into the full command sequence by counting busy edges.
//
// state     | meaning
// ----------+----------------------------------------------------------
// IDLE      | waiting for a request; bus commands hold last value
// CMD0      | address+W and register byte issued, waiting busy rise #1
// CMD1      | data byte (write) or RnW=1 (read) staged, waiting busy rise #2
// STOP_WAIT | enable dropped, waiting for busy fall after STOP
// RESP      | one cycle before the response strobe
module i2c_reg_sequencer #(
   parameter int TIMEOUT_CYC = 200000
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       req_valid,
   output logic       req_ready,
   input  logic       req_rnw,
   input  logic [6:0] req_dev,
   input  logic [7:0] req_reg,
   input  logic [7:0] req_wdata,
   output logic       rsp_valid,
   output logic [7:0] rsp_rdata,
   output logic       rsp_nack,
   output logic       rsp_timeout,
   output logic       m_enable,
   output logic [6:0] m_slv_addr,
   output logic       m_RnW,
   output logic [7:0] m_data_wr,
   input  logic       m_busy,
   input  logic [7:0] m_rd_data,
   input  logic       m_nAck
);

   localparam int CW = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
   localparam logic [CW-1:0] TC_LAST = CW'(TIMEOUT_CYC - 1);

   localparam logic [2:0] IDLE      = 3'd0;
   localparam logic [2:0] CMD0      = 3'd1;
   localparam logic [2:0] CMD1      = 3'd2;
   localparam logic [2:0] STOP_WAIT = 3'd3;
   localparam logic [2:0] RESP      = 3'd4;

   logic [2:0]    state_q, state_d;
   logic          busy_q;
   logic          live_q;
   logic          rnw_q, rnw_d;
   logic [7:0]    wdata_q, wdata_d;
   logic          en_q, en_d;
   logic [6:0]    addr_q, addr_d;
   logic          mrnw_q, mrnw_d;
   logic [7:0]    dwr_q, dwr_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          nack_q, nack_d;
   logic          tmo_q, tmo_d;
   logic [7:0]    rdata_q, rdata_d;
   logic          rsp_q, rsp_d;

   logic busy_rise, busy_fall, in_xfer;

   assign busy_rise = m_busy & ~busy_q;
   assign busy_fall = ~m_busy & busy_q;
   assign in_xfer   = (state_q == CMD0) || (state_q == CMD1) || (state_q == STOP_WAIT);

   // live_q keeps req_ready low while reset is asserted; rsp_q delays it one
   // cycle past the response strobe.
   assign req_ready = live_q & (state_q == IDLE) & ~m_busy & ~rsp_q;

   always_comb begin
      state_d = state_q;
      rnw_d   = rnw_q;
      wdata_d = wdata_q;
      en_d    = en_q;
      addr_d  = addr_q;
      mrnw_d  = mrnw_q;
      dwr_d   = dwr_q;
      cnt_d   = cnt_q;
      nack_d  = nack_q;
      tmo_d   = tmo_q;
      rdata_d = rdata_q;
      rsp_d   = 1'b0;

      if (in_xfer) begin
         if (busy_rise | busy_fall) begin
            cnt_d = '0;
         end else if (cnt_q != TC_LAST) begin
            cnt_d = cnt_q + CW'(1);
         end
      end

      case (state_q)
         IDLE: begin
            if (req_valid & req_ready) begin
               rnw_d   = req_rnw;
               wdata_d = req_wdata;
               addr_d  = req_dev;
               mrnw_d  = 1'b0;
               dwr_d   = req_reg;
               en_d    = 1'b1;
               cnt_d   = '0;
               nack_d  = 1'b0;
               tmo_d   = 1'b0;
               rdata_d = 8'h00;
               state_d = CMD0;
            end
         end
         CMD0: begin
            if (busy_rise) begin
               if (rnw_q) begin
                  mrnw_d = 1'b1;
               end else begin
                  dwr_d = wdata_q;
               end
               state_d = CMD1;
            end
         end
         CMD1: begin
            if (busy_rise) begin
               en_d    = 1'b0;
               state_d = STOP_WAIT;
            end
         end
         STOP_WAIT: begin
            if (busy_fall) begin
               if (rnw_q & ~nack_q) begin
                  rdata_d = m_rd_data;
               end
               state_d = RESP;
            end
         end
         RESP: begin
            rsp_d   = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase

      // Timeout overrides NACK; both flags survive into the response.
      if (in_xfer & m_busy & m_nAck) begin
         nack_d  = 1'b1;
         en_d    = 1'b0;
         rdata_d = 8'h00;
         state_d = STOP_WAIT;
      end
      if (in_xfer && (cnt_q == TC_LAST)) begin
         en_d    = 1'b0;
         tmo_d   = 1'b1;
         rdata_d = 8'h00;
         state_d = RESP;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         busy_q  <= 1'b0;
         live_q  <= 1'b0;
         rnw_q   <= 1'b0;
         wdata_q <= 8'h00;
         en_q    <= 1'b0;
         addr_q  <= 7'h00;
         mrnw_q  <= 1'b0;
         dwr_q   <= 8'h00;
         cnt_q   <= '0;
         nack_q  <= 1'b0;
         tmo_q   <= 1'b0;
         rdata_q <= 8'h00;
         rsp_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         busy_q  <= m_busy;
         live_q  <= 1'b1;
         rnw_q   <= rnw_d;
         wdata_q <= wdata_d;
         en_q    <= en_d;
         addr_q  <= addr_d;
         mrnw_q  <= mrnw_d;
         dwr_q   <= dwr_d;
         cnt_q   <= cnt_d;
         nack_q  <= nack_d;
         tmo_q   <= tmo_d;
         rdata_q <= rdata_d;
         rsp_q   <= rsp_d;
      end
   end

   assign m_enable    = en_q;
   assign m_slv_addr  = addr_q;
   assign m_RnW       = mrnw_q;
   assign m_data_wr   = dwr_q;
   assign rsp_valid   = rsp_q;
   assign rsp_rdata   = rdata_q;
   assign rsp_nack    = nack_q;
   assign rsp_timeout = tmo_q;

endmodule

// File: tb/tb_i2c_reg_sequencer.sv
// Bench for i2c_reg_sequencer: behavioural i2c_master model logging bus events,
// table of register accesses plus timeout, back-to-back and reset sequences.
module tb_i2c_reg_sequencer;

   localparam int TO   = 1000;
   localparam int BYTE = 20;
   localparam logic [8:0] BS = 9'h100;
   localparam logic [8:0] BR = 9'h101;
   localparam logic [8:0] BP = 9'h102;
   localparam logic [8:0] BZ = 9'h000;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       req_valid = 1'b0;
   logic       req_ready;
   logic       req_rnw = 1'b0;
   logic [6:0] req_dev = 7'h00;
   logic [7:0] req_reg = 8'h00;
   logic [7:0] req_wdata = 8'h00;
   logic       rsp_valid;
   logic [7:0] rsp_rdata;
   logic       rsp_nack;
   logic       rsp_timeout;
   logic       m_enable;
   logic [6:0] m_slv_addr;
   logic       m_RnW;
   logic [7:0] m_data_wr;
   logic       m_busy = 1'b0;
   logic [7:0] m_rd_data = 8'h00;
   logic       m_nAck = 1'b0;

   i2c_reg_sequencer #(.TIMEOUT_CYC(TO)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready), .req_rnw(req_rnw),
      .req_dev(req_dev), .req_reg(req_reg), .req_wdata(req_wdata),
      .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_nack(rsp_nack),
      .rsp_timeout(rsp_timeout),
      .m_enable(m_enable), .m_slv_addr(m_slv_addr), .m_RnW(m_RnW),
      .m_data_wr(m_data_wr), .m_busy(m_busy), .m_rd_data(m_rd_data),
      .m_nAck(m_nAck)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int rsp_cnt = 0;
   logic [8:0] bus[$];
   logic       mdl_en = 1'b1;
   logic       nack_addr = 1'b0;
   logic [7:0] slave_rd = 8'h00;
   int         nack_en_seen = -1;

   initial forever begin
      @(posedge clk);
      cyc = cyc + 1;
   end

   initial forever begin
      @(negedge clk);
      if (rsp_valid) rsp_cnt = rsp_cnt + 1;
   end

   // Master model: busy rises when a command is latched, drops for one cycle
   // between chained bytes, and drops for good after STOP.
   localparam int M_IDLE = 0, M_DLY = 1, M_ADDR = 2, M_DATA = 3, M_GAP = 4, M_NACK = 5;
   int         ms = M_IDLE;
   int         mcnt = 0;
   logic       cur_r = 1'b0;
   logic [7:0] cur_d = 8'h00;

   initial forever begin
      @(negedge clk);
      if (!rst_n) begin
         ms = M_IDLE; m_busy = 1'b0; m_nAck = 1'b0; mcnt = 0;
      end else begin
         case (ms)
            M_IDLE: if (mdl_en && m_enable) begin ms = M_DLY; mcnt = 3; end
            M_DLY: if (mcnt > 1) mcnt = mcnt - 1;
               else begin
                  cur_r = m_RnW; cur_d = m_data_wr; m_nAck = 1'b0; m_busy = 1'b1;
                  bus.push_back(BS); bus.push_back({1'b0, m_slv_addr, m_RnW});
                  ms = M_ADDR; mcnt = BYTE;
               end
            M_ADDR: if (mcnt > 1) mcnt = mcnt - 1;
               else if (nack_addr) begin
                  m_nAck = 1'b1; nack_en_seen = -1; ms = M_NACK; mcnt = 2;
               end else begin
                  ms = M_DATA; mcnt = BYTE;
               end
            M_DATA: if (mcnt > 1) mcnt = mcnt - 1;
               else begin
                  if (cur_r) begin m_rd_data = slave_rd; bus.push_back({1'b0, slave_rd}); end
                  else bus.push_back({1'b0, cur_d});
                  m_busy = 1'b0;
                  if (m_enable) ms = M_GAP;
                  else begin bus.push_back(BP); ms = M_IDLE; end
               end
            M_GAP: begin
               m_busy = 1'b1; cur_d = m_data_wr; mcnt = BYTE;
               if (m_RnW !== cur_r) begin
                  cur_r = m_RnW; bus.push_back(BR); bus.push_back({1'b0, m_slv_addr, m_RnW});
                  ms = M_ADDR;
               end else ms = M_DATA;
            end
            M_NACK: if (mcnt > 1) begin nack_en_seen = int'(m_enable); mcnt = mcnt - 1; end
               else begin bus.push_back(BP); m_busy = 1'b0; m_nAck = 1'b0; ms = M_IDLE; end
            default: ms = M_IDLE;
         endcase
      end
   end

   typedef struct {
      logic       rnw;
      logic [6:0] dev;
      logic [7:0] rg;
      logic [7:0] wd;
      logic [7:0] srd;
      logic       nack;
      logic [7:0] e_rdata;
      logic       e_nack;
      int         e_len;
      logic [6:0][8:0] e_bus;
   } vec_t;

   vec_t vecs[6];

   function automatic vec_t mk(input logic rnw, input logic [6:0] dev, input logic [7:0] rg,
                               input logic [7:0] wd, input logic [7:0] srd, input logic nack,
                               input logic [7:0] e_rdata, input int e_len,
                               input logic [6:0][8:0] e_bus);
      vec_t v;
      v.rnw = rnw; v.dev = dev; v.rg = rg; v.wd = wd; v.srd = srd; v.nack = nack;
      v.e_rdata = e_rdata; v.e_nack = nack; v.e_len = e_len; v.e_bus = e_bus;
      return v;
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks = checks + 1;
      if (act !== exp) begin
         errors = errors + 1;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   function automatic logic [28:0] all_out();
      return {m_enable, m_slv_addr, m_RnW, m_data_wr, req_ready, rsp_valid,
              rsp_rdata, rsp_nack, rsp_timeout};
   endfunction

   task automatic send_req(input logic rnw, input logic [6:0] dev, input logic [7:0] rg,
                           input logic [7:0] wd, input string tag);
      int n;
      req_valid = 1'b1; req_rnw = rnw; req_dev = dev; req_reg = rg; req_wdata = wd;
      n = 0;
      while (!req_ready && n < 5000) begin tick(); n++; end
      chk({tag, "_ready_seen"}, 64'(req_ready), 64'd1);
      tick();
      req_valid = 1'b0;
      chk({tag, "_enable_1cyc"}, 64'(m_enable), 64'd1);
   endtask

   task automatic wait_rsp(input int budget, input string tag, output logic got);
      int n;
      n = 0;
      while (!rsp_valid && n < budget) begin tick(); n++; end
      got = rsp_valid;
      chk({tag, "_rsp_seen"}, 64'(got), 64'd1);
   endtask

   task automatic run_vec(input vec_t v, input string tag);
      logic got;
      bus.delete();
      slave_rd = v.srd; nack_addr = v.nack;
      send_req(v.rnw, v.dev, v.rg, v.wd, tag);
      wait_rsp(3000, tag, got);
      if (got) begin
         chk({tag, "_rdata"}, 64'(rsp_rdata), 64'(v.e_rdata));
         chk({tag, "_nack"}, 64'(rsp_nack), 64'(v.e_nack));
         chk({tag, "_timeout"}, 64'(rsp_timeout), 64'd0);
         tick();
         chk({tag, "_rsp_one_cycle"}, 64'(rsp_valid), 64'd0);
         chk({tag, "_ready_after_rsp"}, 64'(req_ready), 64'd1);
      end
      chk({tag, "_bus_len"}, 64'(bus.size()), 64'(v.e_len));
      for (int i = 0; i < v.e_len; i++) begin
         if (i < bus.size()) chk($sformatf("%s_bus%0d", tag, i), 64'(bus[i]), 64'(v.e_bus[i]));
      end
      if (v.nack) chk({tag, "_enable_low_after_nack"}, 64'(nack_en_seen), 64'd0);
      nack_addr = 1'b0;
   endtask

   initial begin
      logic got;
      int n, t0, rsp1_cyc, rc;
      logic [7:0] r1_rdata; logic r1_nack, r1_to;
      logic [8:0] exp_b2b[10];

      vecs[0] = mk(1'b0, 7'h78, 8'h10, 8'h56, 8'h00, 1'b0, 8'h00, 5,
                   {BZ, BZ, BP, 9'h056, 9'h010, 9'h0F0, BS});
      vecs[1] = mk(1'b1, 7'h3C, 8'h2A, 8'h00, 8'hA5, 1'b0, 8'hA5, 7,
                   {BP, 9'h0A5, 9'h079, BR, 9'h02A, 9'h078, BS});
      vecs[2] = mk(1'b0, 7'h22, 8'h33, 8'h44, 8'h00, 1'b1, 8'h00, 3,
                   {BZ, BZ, BZ, BZ, BP, 9'h044, BS});
      vecs[3] = mk(1'b1, 7'h11, 8'h05, 8'h00, 8'h5A, 1'b1, 8'h00, 3,
                   {BZ, BZ, BZ, BZ, BP, 9'h022, BS});
      vecs[4] = mk(1'b1, 7'h7F, 8'hFF, 8'h00, 8'h3C, 1'b0, 8'h3C, 7,
                   {BP, 9'h03C, 9'h0FF, BR, 9'h0FF, 9'h0FE, BS});
      vecs[5] = mk(1'b0, 7'h00, 8'h00, 8'hFF, 8'h00, 1'b0, 8'h00, 5,
                   {BZ, BZ, BP, 9'h0FF, 9'h000, 9'h000, BS});

      // reset state and first ready
      repeat (3) tick();
      chk("reset_outputs", 64'(all_out()), 64'd0);
      rst_n = 1'b1;
      tick();
      chk("ready_after_reset", 64'(req_ready), 64'd1);

      for (int i = 0; i < 6; i++) run_vec(vecs[i], $sformatf("v%0d", i));

      // timeout: master never answers
      mdl_en = 1'b0;
      bus.delete();
      send_req(1'b1, 7'h3C, 8'h2A, 8'h00, "tmo");
      t0 = cyc;
      wait_rsp(TO + 100, "tmo", got);
      if (got) begin
         chk("tmo_latency", 64'(cyc - t0), 64'(TO + 1));
         chk("tmo_flag", 64'(rsp_timeout), 64'd1);
         chk("tmo_nack", 64'(rsp_nack), 64'd0);
         chk("tmo_rdata", 64'(rsp_rdata), 64'd0);
         chk("tmo_enable_low", 64'(m_enable), 64'd0);
         tick();
         chk("tmo_ready_back", 64'(req_ready), 64'd1);
      end
      mdl_en = 1'b1;

      // back-to-back: valid held across two writes
      bus.delete();
      send_req(1'b0, 7'h50, 8'h01, 8'h11, "b2b_a");
      req_valid = 1'b1; req_rnw = 1'b0; req_dev = 7'h51; req_reg = 8'h02; req_wdata = 8'h22;
      rsp1_cyc = -1; n = 0; r1_rdata = 8'hxx; r1_nack = 1'bx; r1_to = 1'bx;
      while (n < 3000) begin
         if (rsp_valid) begin
            rsp1_cyc = cyc; r1_rdata = rsp_rdata; r1_nack = rsp_nack; r1_to = rsp_timeout;
         end
         if (req_ready) break;
         tick(); n++;
      end
      chk("b2b_ready_seen", 64'(req_ready), 64'd1);
      chk("b2b_rsp1_before_ready", 64'(rsp1_cyc != -1), 64'd1);
      chk("b2b_ready_gap", 64'(cyc - rsp1_cyc), 64'd1);
      chk("b2b_busy_low", 64'(m_busy), 64'd0);
      chk("b2b_rsp1_clean", 64'({r1_rdata, r1_nack, r1_to}), 64'd0);
      tick();
      req_valid = 1'b0;
      wait_rsp(3000, "b2b_b", got);
      if (got) chk("b2b_rsp2_clean", 64'({rsp_rdata, rsp_nack, rsp_timeout}), 64'd0);
      tick();
      exp_b2b = '{BS, 9'h0A0, 9'h001, 9'h011, BP, BS, 9'h0A2, 9'h002, 9'h022, BP};
      chk("b2b_bus_len", 64'(bus.size()), 64'd10);
      for (int i = 0; i < 10; i++) begin
         if (i < bus.size()) chk($sformatf("b2b_bus%0d", i), 64'(bus[i]), 64'(exp_b2b[i]));
      end

      // reset during CMD1 of a read
      bus.delete();
      slave_rd = 8'hC3;
      send_req(1'b1, 7'h3C, 8'h2A, 8'h00, "rst");
      n = 0;
      while (!(m_RnW && m_busy) && n < 2000) begin tick(); n++; end
      chk("rst_reached_cmd1", 64'(m_RnW & m_busy), 64'd1);
      rc = rsp_cnt;
      rst_n = 1'b0;
      #1;
      chk("rst_outputs_immediate", 64'(all_out()), 64'd0);
      repeat (3) tick();
      chk("rst_outputs_held", 64'(all_out()), 64'd0);
      rst_n = 1'b1;
      tick();
      chk("rst_ready_after_release", 64'(req_ready), 64'd1);
      repeat (5) tick();
      chk("rst_no_rsp", 64'(rsp_cnt - rc), 64'd0);
      run_vec(vecs[0], "post_rst");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: got simulation still running, expected finish");
      $fatal(1);
   end

endmodule
